// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the y/s datapath sequencer: states, regime codes,
// y source select codes and the RUN-phase cycle limit.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] REG_NONE  = 2'd0;  // abort / no command
  localparam logic [1:0] REG_STEP1 = 2'd1;  // s advances by 1 each cycle
  localparam logic [1:0] REG_STEP2 = 2'd2;  // s advances by 2 each cycle
  localparam logic [1:0] REG_BDRV  = 2'd3;  // s advances by 1 only when b=1

  localparam logic [1:0] YSEL_X     = 2'd0;
  localparam logic [1:0] YSEL_SHIFT = 2'd1;
  localparam logic [1:0] YSEL_ADD   = 2'd2;
  localparam logic [1:0] YSEL_HOLD  = 2'd3;

  // Last RUN-cycle index before forced termination.
  localparam logic [3:0] RUN_LIMIT = 4'd15;

endpackage

// File: rtl/seq_run_cnt.sv
// RUN-phase cycle counter: cleared when a command is accepted, incremented on
// every non-terminating RUN cycle, flags when the last allowed index is reached.
module seq_run_cnt
  import seq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == RUN_LIMIT);

endmodule

// File: rtl/seq_ctrl.sv
// Control automaton for the shared y/s datapath. Accepts a start command with
// a regime, drives the per-cycle datapath strobes and reports progress.
//
//   state | meaning
//   IDLE  | waiting for start with a non-zero regime; all strobes 0
//   INIT  | one cycle: clear s, load y from x and commit
//   RUN   | step s / update y per regime until termination or timeout
//   DONE  | one cycle: done pulse and y commit
module seq_ctrl
  import seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] on,
  input  logic [2:0] s,
  input  logic       b,
  output logic       s_en,
  output logic       s_sub,
  output logic       s_zero,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       y_upd,
  output logic [1:0] y_select_next,
  output logic [1:0] regime,
  output logic       active,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [1:0] regime_q, regime_d;
  logic       err_q, err_d;
  logic       cnt_clr, cnt_inc, at_limit;
  logic       abort, term;

  seq_run_cnt u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .at_limit (at_limit)
  );

  // start with regime 0 cancels an operation in INIT or RUN.
  assign abort = start && (on == REG_NONE);

  // Next state, regime/err updates and combinational strobe decode.
  always_comb begin
    state_d       = state_q;
    regime_d      = regime_q;
    err_d         = err_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    term          = 1'b0;
    s_en          = 1'b0;
    s_sub         = 1'b0;
    s_zero        = 1'b0;
    s_step        = 2'd0;
    y_en          = 1'b0;
    y_upd         = 1'b0;
    y_select_next = YSEL_X;
    case (state_q)
      ST_IDLE: begin
        if (start && (on != REG_NONE)) begin
          regime_d = on;
          err_d    = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          s_en          = 1'b1;
          s_zero        = 1'b1;
          y_en          = 1'b1;
          y_select_next = YSEL_X;
          y_upd         = 1'b1;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        // Termination looks at the current s before any step is issued.
        term = (regime_q == REG_STEP2) ? (s >= 3'd6) : (s == 3'd7);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (term) begin
          state_d = ST_DONE;
        end else if (at_limit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
          case (regime_q)
            REG_STEP1: begin
              s_en          = 1'b1;
              s_step        = 2'd1;
              y_en          = 1'b1;
              y_select_next = YSEL_SHIFT;
            end
            REG_STEP2: begin
              s_en          = 1'b1;
              s_step        = 2'd2;
              y_en          = 1'b1;
              y_select_next = YSEL_SHIFT;
            end
            REG_BDRV: begin
              y_en = 1'b1;
              if (b) begin
                s_en          = 1'b1;
                s_step        = 2'd1;
                y_select_next = YSEL_ADD;
              end else begin
                y_select_next = YSEL_HOLD;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DONE: begin
        y_upd   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, accepted regime and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      regime_q <= REG_NONE;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      regime_q <= regime_d;
      err_q    <= err_d;
    end
  end

  assign regime = regime_q;
  assign err    = err_q;
  assign active = (state_q == ST_INIT) || (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);

endmodule
